// File: rtl/lbp_engine_p_if.sv
// Pixel read port and LBP result port of lbp_engine_p.
// The engine connects as master; the host memory and result sink connect as slave.
interface lbp_engine_p_if #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
);
    logic              gray_ready;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic              lbp_ready;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;

    modport master (
        input  gray_ready, gray_data, lbp_ready,
        output gray_addr, gray_req, lbp_valid, lbp_addr, lbp_data
    );

    modport slave (
        output gray_ready, gray_data, lbp_ready,
        input  gray_addr, gray_req, lbp_valid, lbp_addr, lbp_data
    );
endinterface

// File: rtl/lbp_engine_p.sv
// Streaming 3x3 Local Binary Pattern engine over an IMG_W x IMG_H grey image.
// Optional LBP_BORDER_ZERO_EN: also writes a zero code for every border pixel, full frame in raster order.
module lbp_engine_p #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic           clk,
    input  logic           reset,
    lbp_engine_p_if.master bus,
    output logic           finish
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [2:0] {IDLE, FILL, COL, EMIT, ZERO, DONE} state_t;
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    state_t            state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [1:0]        rr, rr_n;
    logic [1:0]        rc, rc_n;
    win_t              win, win_n;
    logic [ADDR_W-1:0] gray_addr_n;
    logic [ADDR_W-1:0] lbp_addr_n;
    logic [7:0]        lbp_data_n;
    logic              gray_req_n;
    logic              lbp_valid_n;
    logic              rd_done;

`ifdef LBP_BORDER_ZERO_EN
    logic [ADDR_W-1:0] zrow;
    logic [XW-1:0]     zcol;
    assign zrow = bus.lbp_addr >> XW;
    assign zcol = bus.lbp_addr[XW-1:0];
`endif

    // Address of window row r, column c for the window whose left column is xx, centre row yy.
    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [YW-1:0] yy, input logic [XW-1:0] xx,
                                                     input logic [1:0] r, input logic [1:0] c);
        logic [ADDR_W-1:0] row;
        row = ADDR_W'(yy) + ADDR_W'(r) - ADDR_W'(1);
        return (row << XW) + ADDR_W'(xx) + ADDR_W'(c);
    endfunction

    function automatic logic [ADDR_W-1:0] centre_addr(input logic [YW-1:0] yy, input logic [XW-1:0] xx);
        return (ADDR_W'(yy) << XW) + ADDR_W'(xx) + ADDR_W'(1);
    endfunction

    // Bit k is set when neighbour k (TL,T,TR,L,R,BL,B,BR) is not below the centre.
    function automatic logic [7:0] lbp_code(input win_t w);
        logic [PIX_W-1:0] c;
        c = w[1][1];
        return {w[2][2] >= c, w[2][1] >= c, w[2][0] >= c, w[1][2] >= c,
                w[1][0] >= c, w[0][2] >= c, w[0][1] >= c, w[0][0] >= c};
    endfunction

    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        rr_n        = rr;
        rc_n        = rc;
        win_n       = win;
        gray_addr_n = bus.gray_addr;
        lbp_addr_n  = bus.lbp_addr;
        lbp_data_n  = bus.lbp_data;
        rd_done     = bus.gray_req && bus.gray_ready;

        case (state)
            IDLE: begin
                if (bus.gray_ready) begin
`ifdef LBP_BORDER_ZERO_EN
                    state_n    = ZERO;
                    lbp_addr_n = '0;
                    lbp_data_n = '0;
`else
                    state_n = FILL;
                    y_n     = YW'(1);
                    x_n     = '0;
                    rr_n    = 2'd0;
                    rc_n    = 2'd0;
`endif
                end
            end
            // FILL walks rc 0..2, COL starts at rc=2; both finish after the bottom of column 2.
            FILL, COL: begin
                if (rd_done) begin
                    win_n[rr][rc] = bus.gray_data;
                    if (rr == 2'd2) begin
                        rr_n = 2'd0;
                        rc_n = rc + 2'd1;
                        if (rc == 2'd2) state_n = EMIT;
                    end else begin
                        rr_n = rr + 2'd1;
                    end
                end
            end
            EMIT: begin
                if (bus.lbp_ready) begin
                    if (int'(x) + 1 < IMG_W - 2) begin
                        x_n     = x + XW'(1);
                        rr_n    = 2'd0;
                        rc_n    = 2'd2;
                        state_n = COL;
                        for (int r = 0; r < 3; r++) begin
                            win_n[r][0] = win[r][1];
                            win_n[r][1] = win[r][2];
                        end
                    end else begin
`ifdef LBP_BORDER_ZERO_EN
                        state_n    = ZERO;
                        lbp_addr_n = (ADDR_W'(y) << XW) + ADDR_W'(IMG_W - 1);
                        lbp_data_n = '0;
`else
                        if (int'(y) < IMG_H - 2) begin
                            y_n     = y + YW'(1);
                            x_n     = '0;
                            rr_n    = 2'd0;
                            rc_n    = 2'd0;
                            state_n = FILL;
                        end else begin
                            state_n = DONE;
                        end
`endif
                    end
                end
            end
`ifdef LBP_BORDER_ZERO_EN
            // Zero codes advance by one address; column 0 of an interior row hands over to FILL.
            ZERO: begin
                if (bus.lbp_ready) begin
                    if (int'(zrow) > 0 && int'(zrow) < IMG_H - 1 && zcol == '0) begin
                        y_n     = YW'(zrow);
                        x_n     = '0;
                        rr_n    = 2'd0;
                        rc_n    = 2'd0;
                        state_n = FILL;
                    end else if (int'(zrow) == IMG_H - 1 && zcol == XW'(IMG_W - 1)) begin
                        state_n = DONE;
                    end else begin
                        lbp_addr_n = bus.lbp_addr + ADDR_W'(1);
                    end
                end
            end
`endif
            default: ;
        endcase

        gray_req_n  = (state_n == FILL) || (state_n == COL);
        lbp_valid_n = (state_n == EMIT) || (state_n == ZERO);
        if (gray_req_n) gray_addr_n = fetch_addr(y_n, x_n, rr_n, rc_n);
        if (state_n == EMIT && state != EMIT) begin
            lbp_addr_n = centre_addr(y, x);
            lbp_data_n = lbp_code(win_n);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            rr            <= '0;
            rc            <= '0;
            win           <= '0;
            bus.gray_addr <= '0;
            bus.gray_req  <= 1'b0;
            bus.lbp_valid <= 1'b0;
            bus.lbp_addr  <= '0;
            bus.lbp_data  <= '0;
            finish        <= 1'b0;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            rr            <= rr_n;
            rc            <= rc_n;
            win           <= win_n;
            bus.gray_addr <= gray_addr_n;
            bus.gray_req  <= gray_req_n;
            bus.lbp_valid <= lbp_valid_n;
            bus.lbp_addr  <= lbp_addr_n;
            bus.lbp_data  <= lbp_data_n;
            finish        <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_lbp_engine_p.sv
// Randomised self-checking bench for lbp_engine_p: a 32x20 engine and a 4x4 engine
// checked against a raster-order LBP reference model.
module tb_lbp_engine_p;
    localparam int W_A = 32, H_A = 20, AW_A = 10;
    localparam int W_B = 4,  H_B = 4,  AW_B = 4;
`ifdef LBP_BORDER_ZERO_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam int N_A = BORDER ? W_A * H_A : (W_A - 2) * (H_A - 2);
    localparam int N_B = BORDER ? W_B * H_B : (W_B - 2) * (H_B - 2);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b, finish_a, finish_b;
    logic mon_a = 1'b0, mon_b = 1'b0;
    int   checks = 0, errors = 0;
    logic [7:0] mem_a [W_A*H_A];
    logic [7:0] mem_b [W_B*H_B];
    wr_t  exp_a[$], exp_b[$];
    int   rd_a[$], rd_b[$];
    int   nwr_a, nwr_b, first_a, last_a;
    wr_t  ea, eb;

    lbp_engine_p_if #(.ADDR_W(AW_A), .PIX_W(8)) ifa();
    lbp_engine_p_if #(.ADDR_W(AW_B), .PIX_W(8)) ifb();

    lbp_engine_p #(.IMG_W(W_A), .IMG_H(H_A), .PIX_W(8), .ADDR_W(AW_A)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa), .finish(finish_a));
    lbp_engine_p #(.IMG_W(W_B), .IMG_H(H_B), .PIX_W(8), .ADDR_W(AW_B)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb), .finish(finish_b));

    assign ifa.gray_data = mem_a[ifa.gray_addr];
    assign ifb.gray_data = mem_b[ifb.gray_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pix(input bit d, input int a);
        return d ? int'(mem_b[4'(a)]) : int'(mem_a[10'(a)]);
    endfunction

    // Expected writes (raster order) and expected read addresses for one frame.
    task automatic build(input bit d);
        int W, H, c, k;
        wr_t e;
        W = d ? W_B : W_A;
        H = d ? H_B : H_A;
        if (d) begin exp_b.delete(); rd_b.delete(); end
        else   begin exp_a.delete(); rd_a.delete(); end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.addr = 16'(y * W + x);
                e.data = 8'h00;
                if (x > 0 && x < W - 1 && y > 0 && y < H - 1) begin
                    c = pix(d, y * W + x);
                    k = 0;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++)
                            if (dy != 0 || dx != 0) begin
                                if (pix(d, (y + dy) * W + x + dx) >= c) e.data = e.data | (8'd1 << k);
                                k++;
                            end
                    if (d) exp_b.push_back(e); else exp_a.push_back(e);
                end else if (BORDER) begin
                    if (d) exp_b.push_back(e); else exp_a.push_back(e);
                end
            end
        end
        for (int y = 1; y < H - 1; y++)
            for (int x = 0; x < W; x++)
                for (int dy = -1; dy <= 1; dy++)
                    if (d) rd_b.push_back((y + dy) * W + x); else rd_a.push_back((y + dy) * W + x);
    endtask

    logic            hs_stall_a, rd_stall_a, fin_exp_a, fin_exp_b;
    logic [AW_A-1:0] pa_addr, pg_addr;
    logic [7:0]      pa_data;

    always @(negedge clk) begin
        if (!reset_a || !mon_a) begin
            hs_stall_a <= 1'b0;
            rd_stall_a <= 1'b0;
            fin_exp_a  <= 1'b0;
            nwr_a = 0;
        end else begin
            chk("finish_a", finish_a, fin_exp_a);
            if (hs_stall_a) begin
                chk("stall_valid_a", ifa.lbp_valid, 1);
                chk("stall_addr_a", ifa.lbp_addr, pa_addr);
                chk("stall_data_a", ifa.lbp_data, pa_data);
            end
            if (rd_stall_a) chk("gray_hold_a", ifa.gray_addr, pg_addr);
            if (ifa.gray_req && ifa.gray_ready) begin
                if (rd_a.size() == 0) chk("gray_addr_a", ifa.gray_addr, 32'hFFFF_FFFF);
                else chk("gray_addr_a", ifa.gray_addr, rd_a.pop_front());
            end
            if (ifa.lbp_valid && ifa.lbp_ready) begin
                if (nwr_a == 0) first_a = int'(ifa.lbp_addr);
                last_a = int'(ifa.lbp_addr);
                nwr_a++;
                if (exp_a.size() == 0) chk("lbp_addr_a", ifa.lbp_addr, 32'hFFFF_FFFF);
                else begin
                    ea = exp_a.pop_front();
                    chk("lbp_addr_a", ifa.lbp_addr, ea.addr);
                    chk("lbp_data_a", ifa.lbp_data, ea.data);
                    if (exp_a.size() == 0) fin_exp_a <= 1'b1;
                end
            end
            hs_stall_a <= ifa.lbp_valid && !ifa.lbp_ready;
            pa_addr    <= ifa.lbp_addr;
            pa_data    <= ifa.lbp_data;
            rd_stall_a <= ifa.gray_req && !ifa.gray_ready;
            pg_addr    <= ifa.gray_addr;
        end
    end

    always @(negedge clk) begin
        if (!reset_b || !mon_b) begin
            fin_exp_b <= 1'b0;
            nwr_b = 0;
        end else begin
            chk("finish_b", finish_b, fin_exp_b);
            if (ifb.gray_req && ifb.gray_ready) begin
                if (rd_b.size() == 0) chk("gray_addr_b", ifb.gray_addr, 32'hFFFF_FFFF);
                else chk("gray_addr_b", ifb.gray_addr, rd_b.pop_front());
            end
            if (ifb.lbp_valid && ifb.lbp_ready) begin
                nwr_b++;
                if (exp_b.size() == 0) chk("lbp_addr_b", ifb.lbp_addr, 32'hFFFF_FFFF);
                else begin
                    eb = exp_b.pop_front();
                    chk("lbp_addr_b", ifb.lbp_addr, eb.addr);
                    chk("lbp_data_b", ifb.lbp_data, eb.data);
                    if (exp_b.size() == 0) fin_exp_b <= 1'b1;
                end
            end
        end
    end

    task automatic chk_zero_a(input string t);
        chk({t, "_gray_addr"}, ifa.gray_addr, 0);
        chk({t, "_gray_req"},  ifa.gray_req, 0);
        chk({t, "_lbp_valid"}, ifa.lbp_valid, 0);
        chk({t, "_lbp_addr"},  ifa.lbp_addr, 0);
        chk({t, "_lbp_data"},  ifa.lbp_data, 0);
        chk({t, "_finish"},    finish_a, 0);
    endtask

    task automatic start_a();
        reset_a = 1'b0;
        mon_a = 1'b0;
        ifa.gray_ready = 1'b0;
        @(posedge clk); #1;
        reset_a = 1'b1;
        mon_a = 1'b1;
    endtask

    // Drive one frame until finish, a write-count limit, or the cycle budget.
    task automatic run_a(input bit rnd, input int stop_at);
        int n, burst;
        n = 0;
        burst = 0;
        while (!finish_a && n < 30000 && nwr_a < stop_at) begin
            if (rnd) begin
                ifa.lbp_ready = 1'($urandom_range(0, 1));
                if (burst > 0) begin
                    ifa.gray_ready = 1'b0;
                    burst--;
                end else if ($urandom_range(0, 19) == 0) begin
                    ifa.gray_ready = 1'b0;
                    burst = 2;
                end else ifa.gray_ready = 1'b1;
            end else begin
                ifa.lbp_ready = 1'b1;
                ifa.gray_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        reset_a = 1'b0;
        reset_b = 1'b0;
        ifa.gray_ready = 1'b0;
        ifa.lbp_ready = 1'b0;
        ifb.gray_ready = 1'b0;
        ifb.lbp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("reset");
        chk("reset_b_valid", ifb.lbp_valid, 0);

        // 4x4 ramp image: read order, latency and codes.
        for (int i = 0; i < W_B * H_B; i++) mem_b[4'(i)] = 8'(i);
        build(1);
        reset_b = 1'b1;
        mon_b = 1'b1;
        ifb.lbp_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_b", ifb.gray_req, 0);
        ifb.gray_ready = 1'b1;
        n = 0;
        while (!ifb.lbp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("latency_b", n, BORDER ? 1 : 10);
        n = 0;
        while (!finish_b && n < 500) begin @(posedge clk); #1; n++; end
        chk("done_b", finish_b, 1);
        chk("writes_b", nwr_b, N_B);
        chk("reads_left_b", rd_b.size(), 0);
        chk("done_req_b", ifb.gray_req, 0);
        chk("done_valid_b", ifb.lbp_valid, 0);

        // Constant image, no back-pressure: every code is all ones.
        for (int i = 0; i < W_A * H_A; i++) mem_a[10'(i)] = 8'h40;
        build(0);
        start_a();
        run_a(1'b0, 1 << 30);
        chk("t1_finish", finish_a, 1);
        chk("t1_writes", nwr_a, N_A);
        chk("t1_first_addr", first_a, BORDER ? 0 : W_A + 1);
        chk("t1_last_addr", last_a, BORDER ? W_A * H_A - 1 : (H_A - 2) * W_A + W_A - 2);
        chk("t1_done_req", ifa.gray_req, 0);
        chk("t1_done_valid", ifa.lbp_valid, 0);

        // Random image with random sink stalls and read-stall bursts.
        for (int i = 0; i < W_A * H_A; i++) mem_a[10'(i)] = 8'($urandom_range(0, 255));
        build(0);
        start_a();
        run_a(1'b1, 1 << 30);
        chk("t3_finish", finish_a, 1);
        chk("t3_writes", nwr_a, N_A);
        chk("t3_left", exp_a.size(), 0);

        // Low-contrast image, reset mid-frame, then a full restart.
        for (int i = 0; i < W_A * H_A; i++) mem_a[10'(i)] = 8'($urandom_range(0, 3));
        build(0);
        start_a();
        run_a(1'b0, 500);
        chk("t5_reached_500", nwr_a, 500);
        reset_a = 1'b0;
        #1;
        chk_zero_a("t5_reset");
        @(posedge clk); #1;
        build(0);
        reset_a = 1'b1;
        run_a(1'b0, 1 << 30);
        chk("t5_finish", finish_a, 1);
        chk("t5_writes", nwr_a, N_A);
        chk("t5_first_addr", first_a, BORDER ? 0 : W_A + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
